// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - Big-Head-Soccer match sequencer: game FSM, countdown timer, scores, HUD blink
//
// Owns the match flow (IDLE -> KICKOFF -> PLAY <-> GOAL -> OVER), the countdown
// timer, both scores and the HUD blink phase. All timing is in frame ticks.
//
// Optional feature macro: GOLDEN_GOAL_EN
//   defined   - a tie at timer expiry stays in PLAY (sudden death, timer held at 0,
//               HUD blinking); the next goal ends the match with the scorer as winner.
//   undefined - a tie at timer expiry ends the match with winner = 2'b11 (draw).
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   frame_tick  in   one-cycle pulse per frame
//   start_btn   in   one-cycle start pulse (IDLE: start match, OVER: back to IDLE)
//   goal_left   in   one-cycle pulse, credits the right player
//   goal_right  in   one-cycle pulse, credits the left player
//   score_l     out  [3:0] left score
//   score_r     out  [3:0] right score
//   time_sec    out  [6:0] remaining seconds
//   state       out  [2:0] IDLE=0 KICKOFF=1 PLAY=2 GOAL=3 OVER=4
//   freeze      out  high whenever state is not PLAY
//   kickoff     out  one-cycle pulse on the KICKOFF->PLAY transition
//   winner      out  [1:0] 00 none, 01 left, 10 right, 11 draw
//   hud_flash   out  HUD blink phase
module match_ctrl #(
    parameter int FRAMES_PER_SEC    = 60,
    parameter int MATCH_SECONDS     = 90,
    parameter int KICKOFF_FRAMES    = 60,
    parameter int GOAL_PAUSE_FRAMES = 120,
    parameter int MAX_SCORE         = 9,
    parameter int FLASH_FRAMES      = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [6:0] time_sec,
    output logic [2:0] state,
    output logic       freeze,
    output logic       kickoff,
    output logic [1:0] winner,
    output logic       hud_flash
);

    // One shared frame counter serves kickoff, per-second and goal-pause timing.
    localparam int FC_MAX_A = (FRAMES_PER_SEC > KICKOFF_FRAMES) ? FRAMES_PER_SEC : KICKOFF_FRAMES;
    localparam int FC_MAX   = (FC_MAX_A > GOAL_PAUSE_FRAMES) ? FC_MAX_A : GOAL_PAUSE_FRAMES;
    localparam int FC_W     = $clog2(FC_MAX + 1);
    localparam int FL_W     = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KICKOFF = 3'd1,
        S_PLAY    = 3'd2,
        S_GOAL    = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t            r_state, w_state_nx;
    logic [FC_W-1:0]   r_fc, w_fc_nx;
    logic [FL_W-1:0]   r_flc, w_flc_nx;
    logic [3:0]        r_score_l, w_score_l_nx, r_score_r, w_score_r_nx;
    logic [6:0]        r_time_sec, w_time_sec_nx;
    logic              r_freeze, w_freeze_nx;
    logic              r_kickoff, w_kickoff_nx;
    logic [1:0]        r_winner, w_winner_nx;
    logic              r_hud_flash, w_hud_flash_nx;

    logic              w_goal;
    logic              w_flashing;
    logic [3:0]        w_score_l_cr, w_score_r_cr;
    logic [6:0]        w_time_dec;

    function automatic logic [1:0] f_winner(input logic [3:0] l, input logic [3:0] r);
        if (l > r)      return 2'b01;
        else if (r > l) return 2'b10;
        else            return 2'b11;
    endfunction

    assign w_goal       = goal_left | goal_right;
    // Scores as they would be after crediting this cycle's goal pulses (saturating).
    assign w_score_l_cr = (goal_right && r_score_l != 4'(MAX_SCORE)) ? r_score_l + 4'd1 : r_score_l;
    assign w_score_r_cr = (goal_left  && r_score_r != 4'(MAX_SCORE)) ? r_score_r + 4'd1 : r_score_r;
    assign w_time_dec   = (r_time_sec == 7'd0) ? 7'd0 : r_time_sec - 7'd1;

    always_comb begin
        w_state_nx     = r_state;
        w_fc_nx        = r_fc;
        w_flc_nx       = r_flc;
        w_score_l_nx   = r_score_l;
        w_score_r_nx   = r_score_r;
        w_time_sec_nx  = r_time_sec;
        w_kickoff_nx   = 1'b0;
        w_winner_nx    = r_winner;
        w_hud_flash_nx = r_hud_flash;
        w_flashing     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_btn) begin
                    w_score_l_nx  = 4'd0;
                    w_score_r_nx  = 4'd0;
                    w_time_sec_nx = 7'(MATCH_SECONDS);
                    w_winner_nx   = 2'b00;
                    w_fc_nx       = '0;
                    w_state_nx    = S_KICKOFF;
                end
            end
            S_KICKOFF: begin
                if (frame_tick) begin
                    if (r_fc == FC_W'(KICKOFF_FRAMES - 1)) begin
                        w_fc_nx      = '0;
                        w_kickoff_nx = 1'b1;
                        w_state_nx   = S_PLAY;
                    end else begin
                        w_fc_nx = r_fc + 1'b1;
                    end
                end
            end
            S_PLAY: begin
`ifdef GOLDEN_GOAL_EN
                w_flashing = (r_time_sec == 7'd0);
`endif
                // A goal swallows any frame_tick in the same cycle.
                if (w_goal) begin
                    w_score_l_nx = w_score_l_cr;
                    w_score_r_nx = w_score_r_cr;
                    w_fc_nx      = '0;
`ifdef GOLDEN_GOAL_EN
                    if (r_time_sec == 7'd0) begin
                        w_state_nx  = S_OVER;
                        w_winner_nx = f_winner(w_score_l_cr, w_score_r_cr);
                    end else begin
                        w_state_nx = S_GOAL;
                    end
`else
                    w_state_nx = S_GOAL;
`endif
                end else if (frame_tick) begin
                    if (r_fc == FC_W'(FRAMES_PER_SEC - 1)) begin
                        w_fc_nx       = '0;
                        w_time_sec_nx = w_time_dec;
                        if (w_time_dec == 7'd0) begin
`ifdef GOLDEN_GOAL_EN
                            if (r_score_l != r_score_r) begin
                                w_state_nx  = S_OVER;
                                w_winner_nx = f_winner(r_score_l, r_score_r);
                            end
`else
                            w_state_nx  = S_OVER;
                            w_winner_nx = f_winner(r_score_l, r_score_r);
`endif
                        end
                    end else begin
                        w_fc_nx = r_fc + 1'b1;
                    end
                end
            end
            S_GOAL: begin
                w_flashing = 1'b1;
                // Reaching MAX_SCORE ends the match one cycle after entering GOAL.
                if (r_score_l == 4'(MAX_SCORE) || r_score_r == 4'(MAX_SCORE)) begin
                    w_state_nx  = S_OVER;
                    w_winner_nx = f_winner(r_score_l, r_score_r);
                end else if (frame_tick) begin
                    if (r_fc == FC_W'(GOAL_PAUSE_FRAMES - 1)) begin
                        w_fc_nx    = '0;
                        w_state_nx = S_KICKOFF;
                    end else begin
                        w_fc_nx = r_fc + 1'b1;
                    end
                end
            end
            S_OVER: begin
                w_flashing = 1'b1;
                if (start_btn) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Blink phase restarts from 0 on every state change.
        if (w_state_nx != r_state) begin
            w_flc_nx       = '0;
            w_hud_flash_nx = 1'b0;
        end else if (w_flashing && frame_tick) begin
            if (r_flc == FL_W'(FLASH_FRAMES - 1)) begin
                w_flc_nx       = '0;
                w_hud_flash_nx = ~r_hud_flash;
            end else begin
                w_flc_nx = r_flc + 1'b1;
            end
        end

        w_freeze_nx = (w_state_nx != S_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_fc        <= '0;
            r_flc       <= '0;
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_time_sec  <= 7'(MATCH_SECONDS);
            r_freeze    <= 1'b1;
            r_kickoff   <= 1'b0;
            r_winner    <= 2'b00;
            r_hud_flash <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_fc        <= w_fc_nx;
            r_flc       <= w_flc_nx;
            r_score_l   <= w_score_l_nx;
            r_score_r   <= w_score_r_nx;
            r_time_sec  <= w_time_sec_nx;
            r_freeze    <= w_freeze_nx;
            r_kickoff   <= w_kickoff_nx;
            r_winner    <= w_winner_nx;
            r_hud_flash <= w_hud_flash_nx;
        end
    end

    assign state     = r_state;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign time_sec  = r_time_sec;
    assign freeze    = r_freeze;
    assign kickoff   = r_kickoff;
    assign winner    = r_winner;
    assign hud_flash = r_hud_flash;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - randomized scoreboard bench for match_ctrl against a behavioural match model
module tb_match_ctrl;

    localparam int FPS  = 4;
    localparam int MS   = 3;
    localparam int KF   = 2;
    localparam int GP   = 3;
    localparam int MAXS = 2;
    localparam int FL   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, start_btn, goal_left, goal_right;
    logic [3:0] score_l, score_r;
    logic [6:0] time_sec;
    logic [2:0] state;
    logic       freeze, kickoff, hud_flash;
    logic [1:0] winner;

    match_ctrl #(
        .FRAMES_PER_SEC(FPS), .MATCH_SECONDS(MS), .KICKOFF_FRAMES(KF),
        .GOAL_PAUSE_FRAMES(GP), .MAX_SCORE(MAXS), .FLASH_FRAMES(FL)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .goal_left(goal_left), .goal_right(goal_right),
        .score_l(score_l), .score_r(score_r), .time_sec(time_sec), .state(state),
        .freeze(freeze), .kickoff(kickoff), .winner(winner), .hud_flash(hud_flash)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [6:0] tm;
        logic       fz;
        logic       kk;
        logic [1:0] wn;
        logic       fl;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural match model: phase numbers are the visible state codes.
    int m_st, m_fc, m_flc, m_sl, m_sr, m_tm, m_wn;
    bit m_fz, m_kk, m_fl;

    function automatic int sat_inc(input int v);
        return (v >= MAXS) ? MAXS : v + 1;
    endfunction

    function automatic int judge(input int l, input int r);
        if (l > r) return 1;
        if (r > l) return 2;
        return 3;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st = 3'(m_st); o.sl = 4'(m_sl); o.sr = 4'(m_sr); o.tm = 7'(m_tm);
        o.fz = m_fz; o.kk = m_kk; o.wn = 2'(m_wn); o.fl = m_fl;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.st = state; o.sl = score_l; o.sr = score_r; o.tm = time_sec;
        o.fz = freeze; o.kk = kickoff; o.wn = winner; o.fl = hud_flash;
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_fc = 0; m_flc = 0; m_sl = 0; m_sr = 0; m_tm = MS; m_wn = 0;
        m_fz = 1; m_kk = 0; m_fl = 0;
    endtask

    task automatic model_step(input bit st, input bit tk, input bit gl, input bit gr);
        int ns;
        bit flashing;
        bit sudden;
        ns = m_st;
        flashing = 0;
        m_kk = 0;
        case (m_st)
            0: if (st) begin
                m_sl = 0; m_sr = 0; m_tm = MS; m_wn = 0; m_fc = 0; ns = 1;
            end
            1: if (tk) begin
                m_fc++;
                if (m_fc == KF) begin m_fc = 0; ns = 2; m_kk = 1; end
            end
            2: begin
                sudden = (m_tm == 0);
`ifdef GOLDEN_GOAL_EN
                flashing = sudden;
`endif
                if (gl || gr) begin
                    if (gl) m_sr = sat_inc(m_sr);
                    if (gr) m_sl = sat_inc(m_sl);
                    m_fc = 0;
                    ns = 3;
`ifdef GOLDEN_GOAL_EN
                    if (sudden) begin ns = 4; m_wn = judge(m_sl, m_sr); end
`endif
                end else if (tk) begin
                    m_fc = (m_fc + 1) % FPS;
                    if (m_fc == 0 && m_tm > 0) begin
                        m_tm--;
                        if (m_tm == 0) begin
`ifdef GOLDEN_GOAL_EN
                            if (m_sl != m_sr) begin ns = 4; m_wn = judge(m_sl, m_sr); end
`else
                            ns = 4; m_wn = judge(m_sl, m_sr);
`endif
                        end
                    end
                end
            end
            3: begin
                flashing = 1;
                if (m_sl == MAXS || m_sr == MAXS) begin
                    ns = 4; m_wn = judge(m_sl, m_sr);
                end else if (tk) begin
                    m_fc++;
                    if (m_fc == GP) begin m_fc = 0; ns = 1; end
                end
            end
            default: begin
                flashing = 1;
                if (st) ns = 0;
            end
        endcase
        if (ns != m_st) begin
            m_flc = 0; m_fl = 0;
        end else if (flashing && tk) begin
            m_flc++;
            if (m_flc == FL) begin m_flc = 0; m_fl = ~m_fl; end
        end
        m_fz = (ns != 2);
        m_st = ns;
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output word.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = dut_obs();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got st=%0d sl=%0d sr=%0d tm=%0d fz=%0b kk=%0b wn=%0d fl=%0b expected st=%0d sl=%0d sr=%0d tm=%0d fz=%0b kk=%0b wn=%0d fl=%0b",
                         $time, a.st, a.sl, a.sr, a.tm, a.fz, a.kk, a.wn, a.fl,
                         e.st, e.sl, e.sr, e.tm, e.fz, e.kk, e.wn, e.fl);
            end
        end
    end

    task automatic drive(input bit st, input bit tk, input bit gl, input bit gr);
        @(negedge clk);
        #1;
        start_btn = st; frame_tick = tk; goal_left = gl; goal_right = gr;
        model_step(st, tk, gl, gr);
        exp_q.push_back(model_obs());
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            reset = 1'b1;
            start_btn = 0; frame_tick = 0; goal_left = 0; goal_right = 0;
            model_reset();
            exp_q.push_back(model_obs());
        end
        reset = 1'b0;
    endtask

    task automatic random_cycle(input int goal_pct);
        bit st, tk, gl, gr;
        st = ($urandom_range(0, 99) < 8);
        tk = ($urandom_range(0, 99) < 50);
        gl = ($urandom_range(0, 99) < goal_pct);
        gr = ($urandom_range(0, 99) < goal_pct);
        drive(st, tk, gl, gr);
    endtask

    initial begin
        obs_t a, e;
        int   rates[3];
        bit   found;
        rates[0] = 0; rates[1] = 3; rates[2] = 15;
        reset = 1'b1;
        start_btn = 0; frame_tick = 0; goal_left = 0; goal_right = 0;
        model_reset();
        reset_cycles(3);

        for (int ep = 0; ep < 30; ep++) begin
            int pct;
            pct = rates[ep % 3];
            for (int c = 0; c < 150; c++) random_cycle(pct);
        end

        // Drive into GOAL, then hit reset without a clock edge.
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            random_cycle(15);
            if (m_st == 3) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_goal: GOAL state not reached within 2000 cycles (got state=%0d, required 3)", m_st);
        end else begin
            @(negedge clk);
            #1;
            start_btn = 0; frame_tick = 0; goal_left = 0; goal_right = 0;
            reset = 1'b1;
            model_reset();
            #1;
            a = dut_obs();
            e = model_obs();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL async_reset: got st=%0d sl=%0d sr=%0d tm=%0d fz=%0b wn=%0d fl=%0b expected st=%0d sl=%0d sr=%0d tm=%0d fz=%0b wn=%0d fl=%0b",
                         a.st, a.sl, a.sr, a.tm, a.fz, a.wn, a.fl, e.st, e.sl, e.sr, e.tm, e.fz, e.wn, e.fl);
            end
            exp_q.push_back(model_obs());
            reset_cycles(2);
            for (int c = 0; c < 300; c++) random_cycle(5);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
